// File: rtl/sum_accum_int32_if.sv
// Bus bundle for sum_accum_int32: run control, the input sum stream and the result port.
// Valid/ready: a beat or result transfers on a rising clk edge where valid && ready; once raised,
// valid and its payload stay put until that edge, and ready may be asserted independently of valid.
interface sum_accum_int32_if #(
  parameter int LEN_W = 16
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_sum;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic             out_ovf;
  logic [LEN_W-1:0] out_count;
  logic             busy;

  modport slave (
    input  start, len, abort, in_valid, in_sum, out_ready,
    output in_ready, out_valid, out_result, out_ovf, out_count, busy
  );

  modport master (
    output start, len, abort, in_valid, in_sum, out_ready,
    input  in_ready, out_valid, out_result, out_ovf, out_count, busy
  );
endinterface

// File: rtl/sum_accum_int32.sv
// Streaming int32 reduction: accumulates len beats modulo 2^32 with a sticky signed-overflow flag
// and presents the total on a registered valid/ready result port.
module sum_accum_int32 #(
  parameter int LEN_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sum_accum_int32_if.slave     bus,
  output logic [1:0]           o_dbg_state
);

  // Encoding is visible on o_dbg_state: 0 = IDLE, 1 = ACCUM, 2 = DONE.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [31:0]      r_acc;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len_q;
  logic             r_ovf;
  logic             r_out_valid;
  logic [31:0]      r_out_result;
  logic             r_out_ovf;
  logic [LEN_W-1:0] r_out_count;

  logic             w_in_ready;
  logic             w_beat;
  logic [31:0]      w_sum;
  logic             w_ovf_next;
  logic [LEN_W-1:0] w_cnt_inc;
  logic             w_last;
  logic             w_start_ok;
  logic             w_out_hs;

  assign w_in_ready = (r_state == S_ACCUM);
  // An aborted cycle never counts a beat even though in_ready may read 1.
  assign w_beat     = w_in_ready && bus.in_valid && !bus.abort;
  assign w_sum      = r_acc + bus.in_sum;
  assign w_ovf_next = r_ovf ||
                      ((r_acc[31] == bus.in_sum[31]) && (w_sum[31] != r_acc[31]));
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_last     = w_beat && (w_cnt_inc == r_len_q);
  assign w_start_ok = (r_state == S_IDLE) && bus.start && !bus.abort;
  assign w_out_hs   = (r_state == S_DONE) && r_out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (bus.abort) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (bus.start) w_next_state = (bus.len == '0) ? S_DONE : S_ACCUM;
        S_ACCUM: if (w_last) w_next_state = S_DONE;
        S_DONE:  if (w_out_hs) w_next_state = S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_len_q      <= '0;
      r_ovf        <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_ovf    <= 1'b0;
      r_out_count  <= '0;
    end else if (bus.abort) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_start_ok) begin
        if (bus.len != '0) begin
          r_len_q <= bus.len;
          r_acc   <= '0;
          r_cnt   <= '0;
          r_ovf   <= 1'b0;
        end else begin
          r_out_result <= '0;
          r_out_count  <= '0;
          r_out_ovf    <= 1'b0;
          r_out_valid  <= 1'b1;
        end
      end
      if (w_beat) begin
        r_acc <= w_sum;
        r_cnt <= w_cnt_inc;
        r_ovf <= w_ovf_next;
        if (w_last) begin
          r_out_result <= w_sum;
          r_out_count  <= r_len_q;
          r_out_ovf    <= w_ovf_next;
          r_out_valid  <= 1'b1;
        end
      end
      // Result payload is kept after the handshake; only valid drops.
      if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.busy       = (r_state == S_ACCUM) || (r_state == S_DONE);
  assign bus.out_valid  = r_out_valid;
  assign bus.out_result = r_out_result;
  assign bus.out_ovf    = r_out_ovf;
  assign bus.out_count  = r_out_count;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_sum_accum_int32.sv
// Self-checking bench for sum_accum_int32: directed runs plus randomized runs scored against
// a plain-arithmetic model of the reduction.
module tb_sum_accum_int32;

  localparam int LEN_W = 16;
  localparam int W     = 1 + LEN_W + 32;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  sum_accum_int32_if #(.LEN_W(LEN_W)) bus ();

  sum_accum_int32 #(.LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0]  beat_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: signed int32 addition done in 64 bits, overflow when the true sum leaves int32 range.
  function automatic logic [W-1:0] model(input int n);
    logic [31:0] acc;
    bit          ovf;
    longint      s;
    acc = '0;
    ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = longint'($signed(acc)) + longint'($signed(beat_q[i]));
      if (s > 64'sd2147483647 || s < -64'sd2147483648) ovf = 1'b1;
      acc = acc + beat_q[i];
    end
    return {ovf, LEN_W'(n), acc};
  endfunction

  function automatic logic [W-1:0] observed();
    return {bus.out_ovf, bus.out_count, bus.out_result};
  endfunction

  task automatic start_and_feed(input int n, input int max_gap, input bit poke_start);
    int gap;
    exp_q.push_back(model(n));
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 0);
    check("idle_busy", bus.busy, 0);
    bus.start = 1'b1;
    bus.len   = LEN_W'(n);
    @(negedge clk);
    bus.start = 1'b0;
    bus.len   = LEN_W'($urandom);
    if (n == 0) begin
      check("zlen_valid", bus.out_valid, 1);
      check("zlen_state", dbg_state, ST_DONE);
      return;
    end
    check("accum_busy", bus.busy, 1);
    check("accum_state", dbg_state, ST_ACCUM);
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, max_gap);
      repeat (gap) begin
        if (poke_start) begin
          bus.start = 1'b1;
          bus.len   = LEN_W'($urandom_range(1, 50));
        end
        @(negedge clk);
        bus.start = 1'b0;
        check("stall_no_valid", bus.out_valid, 0);
      end
      bus.in_valid = 1'b1;
      bus.in_sum   = beat_q[i];
      check("beat_in_ready", bus.in_ready, 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_sum   = $urandom;
      if (i < n - 1) check("early_valid", bus.out_valid, 0);
    end
    check("done_valid", bus.out_valid, 1);
  endtask

  task automatic finish_run(input int ready_delay, input bit poke_start);
    logic [W-1:0] e;
    e = exp_q.pop_front();
    repeat (ready_delay) begin
      check("hold_valid", bus.out_valid, 1);
      check("hold_result", observed(), e);
      check("hold_in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    check("result", observed(), e);
    check("done_busy", bus.busy, 1);
    bus.out_ready = 1'b1;
    if (poke_start) begin
      bus.start = 1'b1;
      bus.len   = LEN_W'(5);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    check("hs_valid_low", bus.out_valid, 0);
    check("hs_state_idle", dbg_state, ST_IDLE);
    check("hs_busy_low", bus.busy, 0);
    check("hs_result_kept", observed(), e);
  endtask

  function automatic logic [31:0] rand_beat();
    case ($urandom_range(0, 5))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'(int'($urandom_range(0, 20)) - 10);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.abort     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sum    = '0;
    bus.out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_valid", bus.out_valid, 0);
    check("rst_result", observed(), 0);
    check("rst_busy", bus.busy, 0);
    check("rst_in_ready", bus.in_ready, 0);
    rst_n = 1'b1;

    // Basic run
    beat_q = {32'd1, 32'd2, 32'd3, 32'd4};
    start_and_feed(4, 0, 1'b0);
    finish_run(0, 1'b0);

    // Stalls, backpressure and start pokes while busy
    beat_q = {32'h10, 32'h20, 32'h30};
    start_and_feed(3, 2, 1'b1);
    finish_run(5, 1'b1);

    // Signed overflow, then a wrap without signed overflow
    beat_q = {32'h7FFF_FFFF, 32'h0000_0001};
    start_and_feed(2, 0, 1'b0);
    check("ovf_direct", observed(), {1'b1, 16'd2, 32'h8000_0000});
    finish_run(1, 1'b0);
    beat_q = {32'hFFFF_FFFF, 32'h0000_0001};
    start_and_feed(2, 0, 1'b0);
    check("wrap_direct", observed(), {1'b0, 16'd2, 32'h0});
    finish_run(0, 1'b0);

    // Zero length
    beat_q = {};
    start_and_feed(0, 0, 1'b0);
    finish_run(2, 1'b0);

    // Abort mid-run together with a beat
    beat_q = {32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = LEN_W'(5);
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_sum   = beat_q[i];
      @(negedge clk);
    end
    bus.abort  = 1'b1;
    bus.in_sum = 32'd100;
    @(negedge clk);
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    check("abort_state", dbg_state, ST_IDLE);
    check("abort_busy", bus.busy, 0);
    check("abort_in_ready", bus.in_ready, 0);
    repeat (3) begin
      check("abort_no_valid", bus.out_valid, 0);
      @(negedge clk);
    end
    beat_q = {32'd7};
    start_and_feed(1, 0, 1'b0);
    finish_run(0, 1'b0);

    // Asynchronous reset while a result is pending
    beat_q = {32'd11, 32'd22, 32'd33};
    start_and_feed(3, 1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", bus.out_valid, 0);
    check("arst_result", observed(), 0);
    check("arst_state", dbg_state, ST_IDLE);
    check("arst_busy", bus.busy, 0);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized runs
    for (int r = 0; r < 25; r++) begin
      int n;
      n = $urandom_range(0, 8);
      beat_q = {};
      for (int i = 0; i < n; i++) beat_q.push_back(rand_beat());
      start_and_feed(n, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      finish_run($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    check("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sum_accum_int32.md
Name: sum_accum_int32

Overview:
- Streaming reduction stage that sits directly downstream of the 32-bit ripple adder (`Adder32`).
- Consumes a sequence of 32-bit sums over a valid/ready handshake and accumulates a run-time-programmed number of beats modulo 2^32.
- Presents the final total, a sticky signed-overflow flag and the beat count on a registered valid/ready output.
- Supports PIM reduction kernels, e.g. vector sum built on the element-wise int32 add.

Parameters:
- LEN_W, 16, width of the beat-count / length field; max run length 2^LEN_W-1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a run; honoured only in IDLE.
- len  input  LEN_W  number of beats in the run; sampled when start is honoured.
- abort  input  1  synchronous clear to IDLE from any state; discards the run.
- in_valid  input  1  upstream sum valid.
- in_ready  output  1  block can accept a sum this cycle.
- in_sum  input  32  sum word from the adder (two's complement int32).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_result  output  32  accumulated total modulo 2^32.
- out_ovf  output  1  sticky: at least one accumulation step overflowed as signed int32.
- out_count  output  LEN_W  beats accepted in this run.
- busy  output  1  high in ACCUM or DONE.

Behaviour:
- Reset (async assert, sync deassert handled by the top): state=IDLE; acc=0; cnt=0; len_q=0; ovf=0; out_valid=0; out_result=0; out_ovf=0; out_count=0; busy=0; in_ready=0.
- States: IDLE, ACCUM, DONE. All outputs are registered except in_ready and busy, which are decoded from state.
- IDLE:
  - in_ready=0.
  - start with len!=0: len_q<=len; acc<=0; cnt<=0; ovf<=0; go to ACCUM.
  - start with len==0: out_result<=0, out_count<=0, out_ovf<=0, out_valid<=1; go to DONE next cycle.
- ACCUM:
  - in_ready=1.
  - Beat accepted on in_valid&in_ready: acc<=acc+in_sum, truncated to 32 bits; cnt<=cnt+1.
  - ovf<=ovf | (acc[31]==in_sum[31] && sum[31]!=acc[31]).
  - No accepted beat: acc, cnt and ovf hold. in_valid low or stalls for any duration are legal.
  - Final beat (accepted with cnt+1==len_q): out_result<=acc+in_sum; out_count<=len_q; out_ovf<=updated ovf; out_valid<=1; go to DONE.
  - Latency: out_valid rises exactly 1 cycle after the final beat handshake.
- DONE:
  - in_ready=0.
  - out_valid, out_result, out_ovf and out_count are held stable until out_valid&out_ready.
  - On that handshake: out_valid<=0; go to IDLE. out_result, out_ovf and out_count keep their last values.
  - start is ignored in DONE, including in the handshake cycle; the earliest new start is the cycle after.
- start while busy: ignored; no effect on len_q or acc.
- abort: has priority over every other event in the same cycle.
  - Effects: state<=IDLE; out_valid<=0; acc<=0; cnt<=0; ovf<=0.
  - A beat presented in the same cycle is not counted, although in_ready may still read 1 that cycle; upstream must drop it.
- Wrap-around: the accumulator wraps silently modulo 2^32. out_ovf is the only indication.
- Asynchronous reset mid-run: immediate return to the reset values above. The partial result is lost.

Test Plan:
- Basic run: start, len=4; beats 1,2,3,4 back-to-back -> out_valid 1 cycle after the 4th beat; out_result=10, out_count=4, out_ovf=0; out_ready=1 -> IDLE next cycle.
- Stalls and backpressure: len=3; beats 0x10, 0x20, 0x30 with 2 idle cycles of in_valid=0 between each; out_ready held 0 for 5 cycles -> out_result=0x60 stays stable with out_valid=1 until out_ready; in_ready=0 throughout DONE.
- Wrap and signed overflow: len=2; beats 0x7FFFFFFF, 0x00000001 -> out_result=0x80000000, out_ovf=1. Next run: len=2; beats 0xFFFFFFFF, 0x00000001 -> out_result=0, out_ovf=0.
- Zero length: start with len=0 -> out_valid=1 in the following cycle; out_result=0, out_count=0; no beats consumed (in_ready never 1).
- Abort mid-run: len=5; after 2 beats, abort together with an in_valid beat -> IDLE; busy=0; out_valid never asserted. Next run: len=1, beat 7 -> out_result=7 (no stale accumulation).
- Async reset during DONE: assert rst_n=0 mid-cycle while out_valid=1 -> out_valid=0 and out_result=0 immediately; start ignored while busy (check start pulses in ACCUM leave len_q unchanged).
